dram_line_master: RTL and testbench

- Bus master feeding the DRAM subordinate's AXI-style write/read channels from the CPU/cache side.
- Converts one 128-bit cache-line request into one transaction:
  - write: an AW beat, four 32-bit W beats, then waiting for B.
  - read: an AR beat, then collecting four R beats.
- Returns the completed line or status to the requester.
- One transaction is outstanding at a time.

---
 rtl/dram_line_master_pkg.sv | 22 ++
 rtl/dram_line_master_line_beat_sel.sv | 13 +
 rtl/dram_line_master.sv | 171 +++++++++++++++++
 tb/tb_dram_line_master.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_line_master_pkg.sv
// Shared types and constants for the DRAM cache-line bus master.
// One 128-bit line travels as four 32-bit beats on the W and R channels.
package dram_line_master_pkg;

    localparam int LINE_W     = 128;
    localparam int BEAT_W     = 32;
    localparam int LINE_BEATS = LINE_W / BEAT_W;
    localparam int CNT_W      = 2;

    localparam logic [5:0] ATOP_NONE = 6'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

endpackage

// File: rtl/dram_line_master_line_beat_sel.sv
// Selects one 32-bit word out of a 128-bit line.
// Index 0 returns bits [31:0].
module line_beat_sel
    import dram_line_master_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [CNT_W-1:0]  idx_i,
    output logic [BEAT_W-1:0] word_o
);

    assign word_o = line_i[{idx_i, 5'd0} +: BEAT_W];

endmodule

// File: rtl/dram_line_master.sv
// Turns one cache-line request into a single AXI-style burst (AW+4W+B or AR+4R).
// Only one transaction is in flight; the requester gets a one-cycle completion pulse.
module dram_line_master
    import dram_line_master_pkg::*;
#(
    parameter logic [3:0] MID   = 4'h0,
    parameter int         BEATS = LINE_BEATS
)
(
    input  logic               clk,
    input  logic               rst,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [LINE_W-1:0]  req_wline,
    output logic               resp_valid,
    output logic               resp_err,
    output logic [LINE_W-1:0]  resp_rline,

    output logic               awvalid,
    input  logic               awready,
    output logic [3:0]         awid,
    output logic [31:0]        awaddr,
    output logic [5:0]         awatop,

    output logic               wvalid,
    input  logic               wready,
    output logic [BEAT_W-1:0]  wdata,
    output logic               wlast,

    input  logic               bvalid,
    output logic               bready,
    input  logic [3:0]         bid,
    input  logic               bcomp,

    output logic               arvalid,
    input  logic               arready,
    output logic [3:0]         arid,
    output logic [31:0]        araddr,

    input  logic               rvalid,
    output logic               rready,
    input  logic [3:0]         rid,
    input  logic [BEAT_W-1:0]  rdata,
    input  logic               rlast
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BEATS - 1);
    localparam logic [31:0]      ADDR_MASK = 32'hFFFF_FFF0;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic                drain_q;
    logic [31:0]         addr_q;
    logic [LINE_W-1:0]   wline_q;
    logic [LINE_W-1:0]   rline_q;
    logic [BEAT_W-1:0]   wword;
    logic                lastBeat;

    assign lastBeat = (cnt_q == LAST_CNT);

    line_beat_sel u_wsel (
        .line_i (wline_q),
        .idx_i  (cnt_q),
        .word_o (wword)
    );

    // drain_q marks an over-long read burst: beats are swallowed until rlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr & ADDR_MASK;
                        wline_q <= req_wline;
                        err_q   <= 1'b0;
                        drain_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= req_we ? ST_AW : ST_AR;
                    end
                end
                ST_AW: begin
                    if (awready) state_q <= ST_W;
                end
                ST_W: begin
                    if (wready) begin
                        if (lastBeat) begin
                            cnt_q   <= '0;
                            state_q <= ST_B;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        if (!bcomp || (bid != MID)) err_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (arready) state_q <= ST_R;
                end
                ST_R: begin
                    if (rvalid) begin
                        if (rid != MID) err_q <= 1'b1;
                        if (drain_q) begin
                            if (rlast) begin
                                drain_q <= 1'b0;
                                state_q <= ST_DONE;
                            end
                        end else begin
                            rline_q[{cnt_q, 5'd0} +: BEAT_W] <= rdata;
                            cnt_q <= cnt_q + 2'd1;
                            if (lastBeat) begin
                                if (rlast) begin
                                    state_q <= ST_DONE;
                                end else begin
                                    err_q   <= 1'b1;
                                    drain_q <= 1'b1;
                                end
                            end else if (rlast) begin
                                err_q   <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_err   = resp_valid & err_q;
    assign resp_rline = rline_q;

    assign awvalid = (state_q == ST_AW);
    assign awid    = MID;
    assign awaddr  = addr_q;
    assign awatop  = ATOP_NONE;

    assign wvalid  = (state_q == ST_W);
    assign wdata   = wword;
    assign wlast   = wvalid & lastBeat;

    assign bready  = (state_q == ST_B);

    assign arvalid = (state_q == ST_AR);
    assign arid    = MID;
    assign araddr  = addr_q;

    assign rready  = (state_q == ST_R);

endmodule

// File: tb/tb_dram_line_master.sv
// Directed bench for dram_line_master: zero-wait and stalled writes, reads with
// protocol errors, back-to-back requests and mid-burst reset.
module tb_dram_line_master;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_wline;
    logic         resp_valid;
    logic         resp_err;
    logic [127:0] resp_rline;
    logic         awvalid;
    logic         awready;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [5:0]   awatop;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic         wlast;
    logic         bvalid;
    logic         bready;
    logic [3:0]   bid;
    logic         bcomp;
    logic         arvalid;
    logic         arready;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic         rvalid;
    logic         rready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic         rlast;

    int total = 0;
    int bad   = 0;

    dram_line_master #(.MID(4'h0), .BEATS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wline  (req_wline),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rline (resp_rline),
        .awvalid    (awvalid),
        .awready    (awready),
        .awid       (awid),
        .awaddr     (awaddr),
        .awatop     (awatop),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wlast      (wlast),
        .bvalid     (bvalid),
        .bready     (bready),
        .bid        (bid),
        .bcomp      (bcomp),
        .arvalid    (arvalid),
        .arready    (arready),
        .arid       (arid),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rid        (rid),
        .rdata      (rdata),
        .rlast      (rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Parks every subordinate/requester input and lets the DUT settle back to IDLE.
    task automatic drive_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wline = '0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bcomp     = 1'b0;
        bid       = 4'h0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rid       = 4'h0;
        rdata     = '0;
        rlast     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Issues one read and plays a subordinate returning base+n on beat n.
    task automatic read_run(input logic [31:0] addr, input logic [31:0] base,
                            input int rlastIdx, input int badRidIdx,
                            output logic [127:0] line, output logic err,
                            output int respCyc, output int beats,
                            output logic [31:0] araddrSeen);
        drive_idle();
        line       = 'x;
        err        = 1'bx;
        respCyc    = -1;
        beats      = 0;
        araddrSeen = 'x;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = addr;
        arready    = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (arvalid) araddrSeen = araddr;
            if (resp_valid) begin
                respCyc = cyc;
                line    = resp_rline;
                err     = resp_err;
                break;
            end
            if (rready && beats <= rlastIdx) begin
                rvalid = 1'b1;
                rdata  = base + 32'(beats);
                rlast  = (beats == rlastIdx);
                rid    = (beats == badRidIdx) ? 4'h5 : 4'h0;
                beats++;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        total++;
        if ({awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_valids: got %b want 0000000",
                     {awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_err});
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready);
        end
        total++;
        if (resp_rline !== 128'h0) begin
            bad++;
            $display("[TB] FAIL reset_rline: got %h want 0", resp_rline);
        end
        total++;
        if ({awid, arid, awatop} !== 14'h0) begin
            bad++;
            $display("[TB] FAIL const_ids: got awid=%h arid=%h awatop=%h want 0", awid, arid, awatop);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        logic [31:0] expWords [4];
        logic [31:0] gotAddr;
        int hs;
        int respCyc;
        logic gotErr;
        expWords[0] = 32'h11111111;
        expWords[1] = 32'h22222222;
        expWords[2] = 32'h33333333;
        expWords[3] = 32'h44444444;
        hs      = 0;
        respCyc = -1;
        gotErr  = 1'bx;
        gotAddr = 'x;
        drive_idle();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_1234;
        req_wline = 128'h44444444_33333333_22222222_11111111;
        awready   = 1'b1;
        wready    = 1'b1;
        bvalid    = 1'b1;
        bcomp     = 1'b1;
        bid       = 4'h0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                respCyc = cyc;
                gotErr  = resp_err;
                break;
            end
            if (awvalid) gotAddr = awaddr;
            if (wvalid) begin
                total++;
                if (hs > 3 || wdata !== expWords[hs] || wlast !== (hs == 3)) begin
                    bad++;
                    $display("[TB] FAIL wr0_beat%0d: got wdata=%h wlast=%b want wdata=%h wlast=%b",
                             hs, wdata, wlast, (hs > 3) ? 32'h0 : expWords[hs], (hs == 3));
                end
                hs++;
            end
        end
        total++;
        if (gotAddr !== 32'h0000_1230) begin
            bad++;
            $display("[TB] FAIL wr0_awaddr: got %h want 00001230", gotAddr);
        end
        total++;
        if (hs !== 4) begin
            bad++;
            $display("[TB] FAIL wr0_beats: got %0d want 4", hs);
        end
        total++;
        if (respCyc !== 7 || gotErr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr0_resp: got cycle=%0d err=%b want cycle=7 err=0", respCyc, gotErr);
        end
    endtask

    task automatic test_write_stall();
        logic [127:0] expLine;
        int hs;
        int awCycles;
        int respCyc;
        int addrBad;
        int dataBad;
        logic wTog;
        logic gotErr;
        expLine  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        hs       = 0;
        awCycles = 0;
        respCyc  = -1;
        addrBad  = 0;
        dataBad  = 0;
        wTog     = 1'b0;
        gotErr   = 1'bx;
        drive_idle();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_ABCF;
        req_wline = expLine;
        bvalid    = 1'b1;
        bcomp     = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                respCyc = cyc;
                gotErr  = resp_err;
                break;
            end
            if (awvalid) begin
                if (awaddr !== 32'h0000_ABC0) addrBad++;
                awCycles++;
                awready = (awCycles >= 4);
            end else begin
                awready = 1'b0;
            end
            if (wvalid) begin
                if (hs > 3 || wdata !== expLine[hs*32 +: 32] || wlast !== (hs == 3)) dataBad++;
                wready = wTog;
                if (wTog) hs++;
                wTog = ~wTog;
            end else begin
                wready = 1'b0;
            end
        end
        total++;
        if (addrBad !== 0 || awCycles !== 4) begin
            bad++;
            $display("[TB] FAIL wrs_aw: got awCycles=%0d badAddrCycles=%0d want 4 and 0", awCycles, addrBad);
        end
        total++;
        if (dataBad !== 0) begin
            bad++;
            $display("[TB] FAIL wrs_wdata_stable: got %0d bad W cycles want 0", dataBad);
        end
        total++;
        if (hs !== 4) begin
            bad++;
            $display("[TB] FAIL wrs_beats: got %0d want 4", hs);
        end
        total++;
        if (respCyc !== 14 || gotErr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL wrs_resp: got cycle=%0d err=%b want cycle=14 err=1", respCyc, gotErr);
        end
    endtask

    task automatic test_read();
        logic [127:0] line;
        logic err;
        int respCyc;
        int beats;
        logic [31:0] ar;
        read_run(32'h8000_0010, 32'hA0, 3, -1, line, err, respCyc, beats, ar);
        total++;
        if (ar !== 32'h8000_0010) begin
            bad++;
            $display("[TB] FAIL rd0_araddr: got %h want 80000010", ar);
        end
        total++;
        if (line !== 128'h000000A3_000000A2_000000A1_000000A0 || err !== 1'b0 || respCyc !== 6) begin
            bad++;
            $display("[TB] FAIL rd0_resp: got line=%h err=%b cycle=%0d want line=000000a3000000a2000000a1000000a0 err=0 cycle=6",
                     line, err, respCyc);
        end
    endtask

    task automatic test_read_errors();
        logic [127:0] line;
        logic err;
        int respCyc;
        int beats;
        logic [31:0] ar;
        read_run(32'h0000_2000, 32'hB0, 3, 1, line, err, respCyc, beats, ar);
        total++;
        if (line !== 128'h000000B3_000000B2_000000B1_000000B0 || err !== 1'b1 || respCyc !== 6) begin
            bad++;
            $display("[TB] FAIL rd_badrid: got line=%h err=%b cycle=%0d want line=000000b3000000b2000000b1000000b0 err=1 cycle=6",
                     line, err, respCyc);
        end
        read_run(32'h0000_3000, 32'hC0, 1, -1, line, err, respCyc, beats, ar);
        total++;
        if (line !== 128'h000000B3_000000B2_000000C1_000000C0 || err !== 1'b1 || respCyc !== 4 || beats !== 2) begin
            bad++;
            $display("[TB] FAIL rd_early_rlast: got line=%h err=%b cycle=%0d beats=%0d want line=000000b3000000b2000000c1000000c0 err=1 cycle=4 beats=2",
                     line, err, respCyc, beats);
        end
        read_run(32'h0000_4000, 32'hD0, 5, -1, line, err, respCyc, beats, ar);
        total++;
        if (line !== 128'h000000D3_000000D2_000000D1_000000D0 || err !== 1'b1 || respCyc !== 8 || beats !== 6) begin
            bad++;
            $display("[TB] FAIL rd_late_rlast: got line=%h err=%b cycle=%0d beats=%0d want line=000000d3000000d2000000d1000000d0 err=1 cycle=8 beats=6",
                     line, err, respCyc, beats);
        end
    endtask

    task automatic test_back_to_back();
        int readyBad;
        int firstAr;
        int resp1;
        int resp2;
        int beats;
        logic [127:0] line2;
        logic err2;
        readyBad = 0;
        firstAr  = -1;
        resp1    = -1;
        resp2    = -1;
        beats    = 0;
        line2    = 'x;
        err2     = 1'bx;
        drive_idle();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_5000;
        req_wline = 128'h1;
        awready   = 1'b1;
        wready    = 1'b1;
        bvalid    = 1'b1;
        bcomp     = 1'b1;
        arready   = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                req_we   = 1'b0;
                req_addr = 32'h0000_6000;
            end
            if (cyc <= 8 && req_ready !== (cyc == 8)) readyBad++;
            if (arvalid && firstAr < 0) begin
                firstAr   = cyc;
                req_valid = 1'b0;
            end
            if (resp_valid) begin
                if (resp1 < 0) begin
                    resp1 = cyc;
                end else begin
                    resp2 = cyc;
                    line2 = resp_rline;
                    err2  = resp_err;
                    break;
                end
            end
            if (rready && beats <= 3) begin
                rvalid = 1'b1;
                rdata  = 32'hE0 + 32'(beats);
                rlast  = (beats == 3);
                beats++;
            end else begin
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
        req_valid = 1'b0;
        rvalid    = 1'b0;
        total++;
        if (readyBad !== 0) begin
            bad++;
            $display("[TB] FAIL b2b_req_ready: got %0d wrong cycles want 0", readyBad);
        end
        total++;
        if (firstAr !== 9 || resp1 !== 7 || resp2 !== 14) begin
            bad++;
            $display("[TB] FAIL b2b_timing: got ar=%0d resp1=%0d resp2=%0d want ar=9 resp1=7 resp2=14",
                     firstAr, resp1, resp2);
        end
        total++;
        if (line2 !== 128'h000000E3_000000E2_000000E1_000000E0 || err2 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_read_line: got line=%h err=%b want line=000000e3000000e2000000e1000000e0 err=0",
                     line2, err2);
        end
    endtask

    task automatic test_reset_mid_write();
        int pulses;
        pulses = 0;
        drive_idle();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_7000;
        req_wline = 128'h2;
        awready   = 1'b1;
        wready    = 1'b1;
        bvalid    = 1'b1;
        bcomp     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        total++;
        if (wvalid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_in_w: got wvalid=%b want 1", wvalid);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({awvalid, wvalid, bready, arvalid, rready, resp_valid} !== 6'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_async: got valids=%b req_ready=%b want 000000 and 1",
                     {awvalid, wvalid, bready, arvalid, rready, resp_valid}, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("[TB] FAIL rstmid_no_resp: got %0d pulses want 0", pulses);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write_zero_wait();
        test_write_stall();
        test_read();
        test_read_errors();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
